fm_playback_injector: RTL and testbench

//  Playback-direction counterpart of the fast-monitoring spy path.
//  The spy path captures ULT data into spy memories. This block reads a preloaded

---
 rtl/fm_playback_injector.sv | 211 +++++++++++++++++++++
 tb/tb_fm_playback_injector.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_playback_injector.sv
// fm_playback_injector
// Streams a preloaded playback image out of a spy memory into the ULT data
// path using a valid/ready handshake. It supports single-shot and loop modes
// and has a 2-entry output FIFO that decouples memory read latency from
// downstream back-pressure.
module fm_playback_injector #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 10,
  parameter int PB_MODE_WIDTH  = 2,
  parameter int WRAP_CNT_WIDTH = 16
) (
  input  logic                      clk_hs,
  input  logic                      rst_hs,
  input  logic [PB_MODE_WIDTH-1:0]  playback_mode,
  input  logic                      pb_start,
  input  logic [ADDR_WIDTH-1:0]     last_addr,
  output logic                      mem_rd_en,
  output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic [DATA_WIDTH-1:0]     pb_data,
  output logic                      pb_valid,
  input  logic                      pb_ready,
  output logic                      pb_active,
  output logic                      pb_done,
  output logic [WRAP_CNT_WIDTH-1:0] pb_wrap_count
);

  localparam logic [PB_MODE_WIDTH-1:0] MODE_SINGLE = PB_MODE_WIDTH'(1);
  localparam logic [PB_MODE_WIDTH-1:0] MODE_LOOP   = PB_MODE_WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                    state_q, state_d;
  logic                      start_reg_q, start_reg_d;
  logic                      start_dly_q, start_dly_d;
  logic                      loop_q, loop_d;
  logic [ADDR_WIDTH-1:0]     last_q, last_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [WRAP_CNT_WIDTH-1:0] wrap_q, wrap_d;
  logic                      inflight_q, inflight_d;
  logic [1:0]                count_q, count_d;
  logic [DATA_WIDTH-1:0]     head_q, head_d;
  logic [DATA_WIDTH-1:0]     tail_q, tail_d;

  logic                      start;
  logic                      mode_single;
  logic                      mode_loop;
  logic                      abort;
  logic                      pop;
  logic                      push;
  logic                      rd_room;
  logic                      rd_en;
  logic                      done;
  logic [2:0]                occupancy;

  // Control decode: start edge, abort, handshake and read-issue permission
  always_comb begin
    start       = start_reg_q & ~start_dly_q;
    mode_single = (playback_mode == MODE_SINGLE);
    mode_loop   = (playback_mode == MODE_LOOP);
    abort       = (state_q != S_IDLE) && !(mode_single || mode_loop);
    pop         = (count_q != 2'd0) && pb_ready;
    push        = inflight_q && !abort;
    // A word leaving this cycle frees its slot, so reads continue back-to-back
    // while the FIFO drains. This sustains one word per cycle, and the FIFO
    // still cannot overflow.
    occupancy   = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
    rd_room     = (occupancy < 3'd2);
    rd_en       = (state_q == S_RUN) && !abort && rd_room;
  end

  // Next-state logic: playback FSM, address walk and loop-wrap counter
  always_comb begin
    state_d     = state_q;
    loop_d      = loop_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wrap_d      = wrap_q;
    done        = 1'b0;
    start_reg_d = pb_start;
    start_dly_d = start_reg_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && (mode_single || mode_loop)) begin
          loop_d  = mode_loop;
          last_d  = last_addr;
          addr_d  = '0;
          wrap_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rd_en) begin
          if (addr_q == last_q) begin
            if (loop_q) begin
              addr_d = '0;
              if (wrap_q != '1) begin
                wrap_d = wrap_q + 1'b1;
              end
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if ((count_q == 2'd0) && !inflight_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output FIFO: head register drives pb_data, tail holds the second word
  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = rd_en;
    if (abort) begin
      count_d = '0;
    end else begin
      unique case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = mem_rd_data;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = mem_rd_data;
          end else if (pop) begin
            count_d = 2'd0;
          end else if (push) begin
            tail_d  = mem_rd_data;
            count_d = 2'd2;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d = tail_q;
            if (push) begin
              tail_d = mem_rd_data;
            end else begin
              count_d = 2'd1;
            end
          end
        end
        default: begin
          count_d = '0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk_hs or posedge rst_hs) begin
    if (rst_hs) begin
      state_q     <= S_IDLE;
      start_reg_q <= 1'b0;
      start_dly_q <= 1'b0;
      loop_q      <= 1'b0;
      last_q      <= '0;
      addr_q      <= '0;
      wrap_q      <= '0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      start_reg_q <= start_reg_d;
      start_dly_q <= start_dly_d;
      loop_q      <= loop_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wrap_q      <= wrap_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  // Output drive
  always_comb begin
    mem_rd_en     = rd_en;
    mem_rd_addr   = addr_q;
    pb_data       = head_q;
    pb_valid      = (count_q != 2'd0);
    pb_active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    pb_done       = done;
    pb_wrap_count = wrap_q;
  end

endmodule

// File: tb/tb_fm_playback_injector.sv
// Testbench for fm_playback_injector: directed scenarios plus a per-cycle
// behavioural model of the playback stream checked on every falling edge.
module tb_fm_playback_injector;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int MW = 2;
  localparam int WW = 16;

  logic          clk_hs = 1'b0;
  logic          rst_hs;
  logic [MW-1:0] playback_mode;
  logic          pb_start;
  logic [AW-1:0] last_addr;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] pb_data;
  logic          pb_valid;
  logic          pb_ready;
  logic          pb_active;
  logic          pb_done;
  logic [WW-1:0] pb_wrap_count;

  logic [DW-1:0] mem [0:1023];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_total = 0;
  int done_total = 0;
  int rd_total = 0;

  fm_playback_injector #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PB_MODE_WIDTH(MW), .WRAP_CNT_WIDTH(WW)
  ) dut (
    .clk_hs(clk_hs), .rst_hs(rst_hs), .playback_mode(playback_mode),
    .pb_start(pb_start), .last_addr(last_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .pb_data(pb_data),
    .pb_valid(pb_valid), .pb_ready(pb_ready), .pb_active(pb_active),
    .pb_done(pb_done), .pb_wrap_count(pb_wrap_count)
  );

  always #5 clk_hs = ~clk_hs;

  initial for (int i = 0; i < 1024; i++) mem[i] = 64'hA0 + 64'(i);

  // Synchronous memory: data one cycle after the read strobe
  always @(posedge clk_hs) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  always @(negedge clk_hs) begin
    if (!rst_hs) begin
      if (pb_valid && pb_ready) acc_total <= acc_total + 1;
      if (pb_done) done_total <= done_total + 1;
      if (mem_rd_en) rd_total <= rd_total + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: the k-th read must address k mod (last+1), and the
  // k-th accepted word must be mem[k mod (last+1)]. A single-shot run ends
  // with pb_done in the cycle after the final word is taken.
  logic          m_run = 1'b0, m_run_nx = 1'b0, m_loop = 1'b0;
  logic          m_start_prev = 1'b0, m_rise = 1'b0, m_stall = 1'b0;
  int unsigned   m_len = 1, m_iss = 0, m_dlv = 0, m_wrap = 0;
  logic [DW-1:0] m_stall_data;

  always @(negedge clk_hs) begin : model
    logic abort, exp_done;
    if (rst_hs) begin
      m_run = 0; m_run_nx = 0; m_start_prev = 0; m_rise = 0; m_stall = 0;
      m_wrap = 0; m_iss = 0; m_dlv = 0;
    end else begin
      if (m_run_nx && !m_run) begin m_iss = 0; m_dlv = 0; m_wrap = 0; end
      m_run = m_run_nx;
      abort = m_run && !(playback_mode == 2'd1 || playback_mode == 2'd2);
      exp_done = m_run && !m_loop && !abort && (m_dlv == m_len);
      chk("active", 64'(pb_active), 64'(m_run));
      chk("done", 64'(pb_done), 64'(exp_done));
      chk("wrap", 64'(pb_wrap_count), 64'(m_wrap));
      if (m_stall) begin
        chk("stall_valid", 64'(pb_valid), 64'd1);
        chk("stall_data", pb_data, m_stall_data);
      end
      if (!m_run) chk("valid_idle", 64'(pb_valid), 64'd0);
      else if (pb_valid && pb_ready) begin
        chk("word_data", pb_data, mem[m_dlv % m_len]);
        if (!m_loop) chk("word_in_image", 64'(m_dlv < m_len), 64'd1);
        m_dlv++;
      end
      if (mem_rd_en) begin
        chk("rd_allowed", 64'(m_run && !abort && (m_loop || m_iss < m_len)), 64'd1);
        if (m_run) chk("rd_addr", 64'(mem_rd_addr), 64'(m_iss % m_len));
        if (m_loop && (m_iss % m_len == m_len - 1) && m_wrap < 65535) m_wrap++;
        m_iss++;
      end
      m_run_nx = m_run;
      if (abort || exp_done) m_run_nx = 0;
      if (m_rise && !m_run && (playback_mode == 2'd1 || playback_mode == 2'd2)) begin
        m_run_nx = 1;
        m_loop   = (playback_mode == 2'd2);
        m_len    = int'(last_addr) + 1;
      end
      m_rise       = pb_start && !m_start_prev;
      m_start_prev = pb_start;
      m_stall      = m_run_nx && pb_valid && !pb_ready;
      m_stall_data = pb_data;
    end
  end

  task automatic tick();
    @(posedge clk_hs); #1;
  endtask

  task automatic start_run(input logic [MW-1:0] mode, input logic [AW-1:0] last);
    playback_mode = mode; last_addr = last; pb_start = 1'b1;
    tick();
    pb_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    logic got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_hs);
      if (pb_done) begin got = 1'b1; break; end
    end
    chk(nm, 64'(got), 64'd1);
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(pb_valid), 64'd0);
    chk({tag, "_data"}, pb_data, 64'd0);
    chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    chk({tag, "_active"}, 64'(pb_active), 64'd0);
    chk({tag, "_done"}, 64'(pb_done), 64'd0);
    chk({tag, "_wrap"}, 64'(pb_wrap_count), 64'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int base, dbase;
    logic [31:0] rpat;
    logic got;
    rpat = 32'b1010_0110_1100_1001_0111_0001_1010_0101;
    rst_hs = 1'b1; pb_start = 1'b0; playback_mode = '0; last_addr = '0; pb_ready = 1'b1;
    #1;
    chk_zero("reset");
    tick(); tick();
    rst_hs = 1'b0;
    tick();

    // 1: single-shot, four words at N+4..N+7, done at N+8
    start_run(2'd1, 10'd3);
    repeat (3) @(negedge clk_hs);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_hs);
      chk("t1_valid", 64'(pb_valid), 64'd1);
      chk("t1_data", pb_data, 64'hA0 + 64'(i));
    end
    @(negedge clk_hs);
    chk("t1_done", 64'(pb_done), 64'd1);
    @(negedge clk_hs);
    chk("t1_active_low", 64'(pb_active), 64'd0);
    tick();

    // 2: loop over three words, no bubbles, six full passes after word 18
    start_run(2'd2, 10'd2);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_hs);
      if (pb_valid) begin got = 1'b1; break; end
    end
    chk("t2_first_valid", 64'(got), 64'd1);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk_hs);
      chk("t2_valid", 64'(pb_valid), 64'd1);
      chk("t2_data", pb_data, 64'hA0 + 64'(i % 3));
      if (i == 17) chk("t2_wrap", 64'(pb_wrap_count), 64'd6);
    end
    tick();
    playback_mode = 2'd0;
    repeat (3) tick();

    // 3: single-shot of eight words under a fixed irregular ready pattern
    base = acc_total;
    start_run(2'd1, 10'd7);
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      pb_ready = rpat[k % 32];
      @(negedge clk_hs);
      if (pb_done) begin got = 1'b1; break; end
      tick();
    end
    chk("t3_done", 64'(got), 64'd1);
    tick();
    chk("t3_words", 64'(acc_total - base), 64'd8);
    pb_ready = 1'b1;

    // 4: abort in loop mode, then restart from the first word
    dbase = done_total;
    start_run(2'd2, 10'd5);
    repeat (9) tick();
    playback_mode = 2'd0;
    @(negedge clk_hs);
    @(negedge clk_hs);
    chk("t4_valid_off", 64'(pb_valid), 64'd0);
    chk("t4_active_off", 64'(pb_active), 64'd0);
    chk("t4_rd_off", 64'(mem_rd_en), 64'd0);
    tick();
    repeat (4) tick();
    chk("t4_no_done", 64'(done_total - dbase), 64'd0);
    start_run(2'd1, 10'd2);
    repeat (3) @(negedge clk_hs);
    @(negedge clk_hs);
    chk("t4_restart_data", pb_data, 64'hA0);
    wait_done("t4_done", 30);

    // 5: one-word image, then a start with the reserved mode
    base = acc_total;
    start_run(2'd1, 10'd0);
    wait_done("t5_done", 30);
    chk("t5_words", 64'(acc_total - base), 64'd1);
    base = rd_total;
    start_run(2'd3, 10'd0);
    repeat (10) tick();
    chk("t5_no_reads", 64'(rd_total - base), 64'd0);
    chk("t5_idle", 64'(pb_active), 64'd0);

    // 5b: one-word image in loop mode, one wrap per read
    start_run(2'd2, 10'd0);
    repeat (4) @(negedge clk_hs);
    chk("t5b_data", pb_data, 64'hA0);
    chk("t5b_wrap", 64'(pb_wrap_count), 64'd2);
    @(negedge clk_hs);
    chk("t5b_valid", 64'(pb_valid), 64'd1);
    chk("t5b_wrap2", 64'(pb_wrap_count), 64'd3);
    tick();
    repeat (6) tick();
    playback_mode = 2'd0;
    repeat (3) tick();

    // 6: reset while stalled with a full FIFO, then replay from the start
    pb_ready = 1'b0;
    start_run(2'd2, 10'd1);
    repeat (8) tick();
    @(negedge clk_hs);
    chk("t6_stalled_rd", 64'(mem_rd_en), 64'd0);
    chk("t6_stalled_data", pb_data, 64'hA0);
    chk("t6_wrap_pre", 64'(pb_wrap_count), 64'd1);
    @(posedge clk_hs); #3;
    rst_hs = 1'b1;
    #1;
    chk_zero("t6_async");
    tick(); tick();
    rst_hs = 1'b0;
    pb_ready = 1'b1;
    tick();
    start_run(2'd1, 10'd3);
    repeat (3) @(negedge clk_hs);
    @(negedge clk_hs);
    chk("t6_replay_data", pb_data, 64'hA0);
    wait_done("t6_done", 30);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
